// File: rtl/router_out_rx.sv
// rtl/router_out_rx.sv - serial receive deserializer with byte FIFO for one router output port
//
// router_out_rx: samples frameo_n/valido_n/dout (LSB first), rebuilds bytes,
// reports packet completion or framing errors, and queues {last, byte} in a
// DEPTH-entry FIFO with registered head outputs.
//   clock, reset_n        : clock (rising edge) and async active-low reset
//   frameo_n, valido_n    : active-low frame / bit-valid from the router port
//   dout                  : serial payload bit
//   m_data, m_last        : registered FIFO head byte and its end-of-packet tag
//   m_valid, m_ready      : FIFO non-empty / consumer accept
//   pkt_done, pkt_len     : clean-end pulse and byte count (held until next pulse)
//   pkt_err               : framing-error pulse
//   overflow              : sticky, a byte was dropped on a full FIFO
//
// router_out_rx_fifo: byte queue whose head is held in output registers.
//   wr_valid, wr_data     : push request and {last, byte}
//   rd_ready              : pop request, honoured only while rd_valid
//   rd_data, rd_valid     : registered head entry and non-empty flag
//   overflow              : sticky drop flag

module router_out_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       wr_valid,
  input  logic [8:0] wr_data,
  input  logic       rd_ready,
  output logic [8:0] rd_data,
  output logic       rd_valid,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          pop, accept, bypass;

  assign pop    = rd_valid && rd_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign accept = wr_valid && ((count != CW'(DEPTH)) || pop);
  // The incoming entry becomes the new head when nothing else remains.
  assign bypass = accept && (count == CW'(pop));

  always_comb begin
    rd_nxt    = pop ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt = count + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_nxt;
      count    <= count_nxt;
      rd_valid <= (count_nxt != '0);
      if (count_nxt != '0) rd_data <= bypass ? wr_data : mem[rd_nxt];
      if (wr_valid && !accept) overflow <= 1'b1;
    end
  end
endmodule

module router_out_rx #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             frameo_n,
  input  logic             valido_n,
  input  logic             dout,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             pkt_done,
  output logic [LEN_W-1:0] pkt_len,
  output logic             pkt_err,
  output logic             overflow
);
  typedef enum logic {IDLE, RECV} state_t;

  state_t           state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [LEN_W-1:0] byte_cnt, cnt_inc;
  logic             push_v, push_last;
  logic [7:0]       push_data, byte_full;
  logic             active;
  logic [8:0]       head;

  // IDLE only wakes on frameo_n low, and that cycle counts as a RECV cycle,
  // so frameo_n high can only be seen here while already in RECV.
  assign active    = (state == RECV) || !frameo_n;
  assign byte_full = {dout, shreg[6:0]};
  assign cnt_inc   = (byte_cnt == {LEN_W{1'b1}}) ? byte_cnt : byte_cnt + LEN_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_cnt  <= '0;
      push_v    <= 1'b0;
      push_last <= 1'b0;
      push_data <= '0;
      pkt_done  <= 1'b0;
      pkt_len   <= '0;
      pkt_err   <= 1'b0;
    end else begin
      push_v   <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      if (active) begin
        if (frameo_n) begin
          state    <= IDLE;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          shreg    <= '0;
          if (!valido_n && bit_cnt == 3'd7) begin
            push_v    <= 1'b1;
            push_data <= byte_full;
            push_last <= 1'b1;
            pkt_done  <= 1'b1;
            pkt_len   <= cnt_inc;
          end else begin
            pkt_err <= 1'b1;
          end
        end else begin
          state <= RECV;
          if (!valido_n) begin
            shreg[bit_cnt] <= dout;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              push_v    <= 1'b1;
              push_data <= byte_full;
              push_last <= 1'b0;
              byte_cnt  <= cnt_inc;
            end
          end
        end
      end
    end
  end

  router_out_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_valid (push_v),
    .wr_data  ({push_last, push_data}),
    .rd_ready (m_ready),
    .rd_data  (head),
    .rd_valid (m_valid),
    .overflow (overflow)
  );

  assign m_data = head[7:0];
  assign m_last = head[8];
endmodule

// File: tb/tb_router_out_rx.sv
// tb/tb_router_out_rx.sv - directed self-checking bench for router_out_rx
module tb_router_out_rx;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       frameo_n = 1'b1;
  logic       valido_n = 1'b1;
  logic       dout = 1'b0;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       pkt_done;
  logic [7:0] pkt_len;
  logic       pkt_err;
  logic       overflow;

  router_out_rx #(.DEPTH(8), .LEN_W(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .frameo_n (frameo_n),
    .valido_n (valido_n),
    .dout     (dout),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .pkt_done (pkt_done),
    .pkt_len  (pkt_len),
    .pkt_err  (pkt_err),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  int         tests_run = 0;
  int         fails = 0;
  logic [8:0] rx_q[$];
  int         done_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] last_len = 8'h00;

  // Inputs change 1 time unit after the rising edge, so the falling-edge
  // samples below see exactly what the next rising edge will use.
  always @(negedge clock) begin
    if (reset_n) begin
      if (m_valid && m_ready) rx_q.push_back({m_last, m_data});
      if (pkt_done) begin
        done_cnt++;
        last_len = pkt_len;
      end
      if (pkt_err) err_cnt++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic f, input logic v, input logic d);
    frameo_n = f;
    valido_n = v;
    dout     = d;
    step();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last,
                           input int gap_after, input int gaps);
    for (int i = 0; i < 8; i++) begin
      drive(last && (i == 7), 1'b0, b[i]);
      if (i == gap_after)
        for (int g = 0; g < gaps; g++) drive(1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    tests_run++; if (m_valid !== 1'b0)  begin fails++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    tests_run++; if (m_data !== 8'h00)  begin fails++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
    tests_run++; if (m_last !== 1'b0)   begin fails++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
    tests_run++; if (pkt_done !== 1'b0) begin fails++; $display("FAIL reset_pkt_done got=%b exp=0", pkt_done); end
    tests_run++; if (pkt_len !== 8'h00) begin fails++; $display("FAIL reset_pkt_len got=%h exp=00", pkt_len); end
    tests_run++; if (pkt_err !== 1'b0)  begin fails++; $display("FAIL reset_pkt_err got=%b exp=0", pkt_err); end
    tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    clear_mon();
    m_ready = 1'b1;
    send_byte(8'hA5, 1'b1, -1, 0);
    tests_run++; if (pkt_done !== 1'b1) begin fails++; $display("FAIL single_done_pulse got=%b exp=1", pkt_done); end
    tests_run++; if (pkt_len !== 8'd1)  begin fails++; $display("FAIL single_pkt_len got=%0d exp=1", pkt_len); end
    tests_run++; if (m_valid !== 1'b0)  begin fails++; $display("FAIL single_early_valid got=%b exp=0", m_valid); end
    idle(1);
    tests_run++; if ({m_valid, m_last, m_data} !== {1'b1, 1'b1, 8'hA5})
      begin fails++; $display("FAIL single_head got=v%b l%b %h exp=v1 l1 a5", m_valid, m_last, m_data); end
    tests_run++; if (pkt_done !== 1'b0) begin fails++; $display("FAIL single_done_width got=%b exp=0", pkt_done); end
    idle(3);
    tests_run++; if (rx_q.size() != 1 || rx_q[0] !== 9'h1A5)
      begin fails++; $display("FAIL single_stream got_n=%0d exp_n=1 exp=1a5", rx_q.size()); end
    tests_run++; if (done_cnt != 1 || err_cnt != 0)
      begin fails++; $display("FAIL single_pulses got done=%0d err=%0d exp done=1 err=0", done_cnt, err_cnt); end
  endtask

  task automatic test_gaps();
    logic [8:0] exp_q [3];
    logic [8:0] got;
    exp_q[0] = 9'h001; exp_q[1] = 9'h080; exp_q[2] = 9'h1FF;
    clear_mon();
    send_byte(8'h01, 1'b0, -1, 0);
    send_byte(8'h80, 1'b0, 3, 2);
    send_byte(8'hFF, 1'b1, -1, 0);
    idle(4);
    tests_run++; if (rx_q.size() != 3) begin fails++; $display("FAIL gaps_count got=%0d exp=3", rx_q.size()); end
    for (int k = 0; k < 3; k++) begin
      got = (k < rx_q.size()) ? rx_q[k] : 9'bx;
      tests_run++; if (got !== exp_q[k]) begin fails++; $display("FAIL gaps_byte%0d got=%h exp=%h", k, got, exp_q[k]); end
    end
    tests_run++; if (done_cnt != 1 || last_len !== 8'd3)
      begin fails++; $display("FAIL gaps_len got done=%0d len=%0d exp done=1 len=3", done_cnt, last_len); end
  endtask

  task automatic test_frame_err();
    logic [7:0] b;
    b = 8'h15;
    clear_mon();
    send_byte(8'h3C, 1'b0, -1, 0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, b[i]);
    drive(1'b1, 1'b1, 1'b0);
    tests_run++; if (pkt_err !== 1'b1) begin fails++; $display("FAIL err_pulse got=%b exp=1", pkt_err); end
    idle(4);
    tests_run++; if (rx_q.size() != 1 || rx_q[0] !== 9'h03C)
      begin fails++; $display("FAIL err_partial got_n=%0d exp_n=1 exp=03c", rx_q.size()); end
    tests_run++; if (err_cnt != 1 || done_cnt != 0)
      begin fails++; $display("FAIL err_pulses got err=%0d done=%0d exp err=1 done=0", err_cnt, done_cnt); end
    // End flagged with a valid bit but mid-byte is also a framing error.
    clear_mon();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    idle(3);
    tests_run++; if (err_cnt != 1 || done_cnt != 0 || rx_q.size() != 0)
      begin fails++; $display("FAIL err_short got err=%0d done=%0d n=%0d exp err=1 done=0 n=0", err_cnt, done_cnt, rx_q.size()); end
    clear_mon();
    send_byte(8'h11, 1'b1, -1, 0);
    idle(3);
    tests_run++; if (rx_q.size() != 1 || rx_q[0] !== 9'h111 || done_cnt != 1 || last_len !== 8'd1)
      begin fails++; $display("FAIL err_recover got_n=%0d done=%0d len=%0d exp 111 done=1 len=1", rx_q.size(), done_cnt, last_len); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] got0, got1;
    clear_mon();
    send_byte(8'h5A, 1'b1, -1, 0);
    send_byte(8'hC3, 1'b1, -1, 0);
    idle(4);
    got0 = (rx_q.size() > 0) ? rx_q[0] : 9'bx;
    got1 = (rx_q.size() > 1) ? rx_q[1] : 9'bx;
    tests_run++; if (got0 !== 9'h15A || got1 !== 9'h1C3 || rx_q.size() != 2)
      begin fails++; $display("FAIL b2b_stream got=%h %h n=%0d exp=15a 1c3 n=2", got0, got1, rx_q.size()); end
    tests_run++; if (done_cnt != 2 || err_cnt != 0)
      begin fails++; $display("FAIL b2b_pulses got done=%0d err=%0d exp done=2 err=0", done_cnt, err_cnt); end
  endtask

  task automatic test_backpressure();
    logic [8:0] got;
    clear_mon();
    m_ready = 1'b0;
    for (int k = 0; k < 10; k++) send_byte(8'(k), (k == 9), -1, 0);
    idle(3);
    tests_run++; if (overflow !== 1'b1) begin fails++; $display("FAIL bp_overflow got=%b exp=1", overflow); end
    tests_run++; if (done_cnt != 1 || last_len !== 8'd10)
      begin fails++; $display("FAIL bp_len got done=%0d len=%0d exp done=1 len=10", done_cnt, last_len); end
    tests_run++; if ({m_valid, m_last, m_data} !== {1'b1, 1'b0, 8'h00})
      begin fails++; $display("FAIL bp_head got=v%b l%b %h exp=v1 l0 00", m_valid, m_last, m_data); end
    m_ready = 1'b1;
    idle(12);
    tests_run++; if (rx_q.size() != 8) begin fails++; $display("FAIL bp_drain_count got=%0d exp=8", rx_q.size()); end
    for (int k = 0; k < 8; k++) begin
      got = (k < rx_q.size()) ? rx_q[k] : 9'bx;
      tests_run++; if (got !== {1'b0, 8'(k)}) begin fails++; $display("FAIL bp_byte%0d got=%h exp=%h", k, got, {1'b0, 8'(k)}); end
    end
    tests_run++; if (m_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got=%b exp=0", m_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h99;
    clear_mon();
    m_ready = 1'b0;
    send_byte(8'h12, 1'b0, -1, 0);
    send_byte(8'h34, 1'b0, -1, 0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, b[i]);
    tests_run++; if (m_valid !== 1'b1 || m_data !== 8'h12)
      begin fails++; $display("FAIL rst_pre_head got=v%b %h exp=v1 12", m_valid, m_data); end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++; if ({m_valid, pkt_done, pkt_err, overflow} !== 4'b0000)
      begin fails++; $display("FAIL rst_async got=v%b d%b e%b o%b exp=all 0", m_valid, pkt_done, pkt_err, overflow); end
    frameo_n = 1'b1;
    valido_n = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    m_ready = 1'b1;
    idle(1);
    clear_mon();
    send_byte(8'h7E, 1'b1, -1, 0);
    idle(3);
    tests_run++; if (rx_q.size() != 1 || rx_q[0] !== 9'h17E || done_cnt != 1 || last_len !== 8'd1)
      begin fails++; $display("FAIL rst_next_pkt got_n=%0d done=%0d len=%0d exp 17e done=1 len=1", rx_q.size(), done_cnt, last_len); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_frame_err();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
